// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and two-stage sequencer in front of the
// single-port data RAM. Port 0 is the core load/store unit and port 1 is the
// debug/loader port. Out-of-range accesses never reach the RAM, but they still
// get an error response so that the requester's in-order bookkeeping stays intact.
module ram_arbiter #(
  parameter int DEPTH = 2561,
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [3:0]       p0_be,
  input  logic [31:0]      p0_addr,
  input  logic [31:0]      p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [31:0]      p0_rdata,
  output logic             p0_err,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [3:0]       p1_be,
  input  logic [31:0]      p1_addr,
  input  logic [31:0]      p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [31:0]      p1_rdata,
  output logic             p1_err,
  output logic             ram_is_store,
  output logic             ram_is_load,
  output logic [3:0]       ram_w_enable,
  output logic [IDX_W-1:0] ram_addr,
  output logic [31:0]      ram_w_data,
  input  logic [31:0]      ram_r_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  // last = port granted most recently; the other port wins a tie.
  logic        last;
  logic        gnt0, gnt1, acc;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr, sel_wdata, sel_idx;
  logic        sel_ok;
  logic        unused_addr_lsb;

  logic        s1_valid, s1_port, s1_load, s1_err;
  logic        s2_valid, s2_port, s2_load, s2_err;

  // Round-robin grant: a lone requester always wins; on a tie the port that was not granted last wins.
  always_comb begin
    gnt0 = p0_req && (!p1_req || last);
    gnt1 = p1_req && (!p0_req || !last);
    acc  = gnt0 || gnt1;
  end

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  // Mux the granted port's command and range-check its word index.
  always_comb begin
    sel_we    = gnt1 ? p1_we    : p0_we;
    sel_be    = gnt1 ? p1_be    : p0_be;
    sel_addr  = gnt1 ? p1_addr  : p0_addr;
    sel_wdata = gnt1 ? p1_wdata : p0_wdata;
    sel_idx   = {2'b00, sel_addr[31:2]};
    sel_ok    = (sel_idx < DEPTH_W);
  end

  assign unused_addr_lsb = ^sel_addr[1:0];

  // Round-robin pointer; it holds on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= 1'b1;
    else if (acc) last <= gnt1;
  end

  // Stage S1: registered RAM command plus the response tag for the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_is_store <= 1'b0;
      ram_is_load  <= 1'b0;
      ram_w_enable <= '0;
      ram_addr     <= '0;
      ram_w_data   <= '0;
      s1_valid     <= 1'b0;
      s1_port      <= 1'b0;
      s1_load      <= 1'b0;
      s1_err       <= 1'b0;
    end else begin
      s1_valid <= acc;
      s1_port  <= gnt1;
      s1_load  <= !sel_we;
      s1_err   <= !sel_ok;
      if (acc && sel_ok) begin
        ram_is_store <= sel_we;
        ram_is_load  <= !sel_we;
        ram_w_enable <= sel_we ? sel_be : 4'b0000;
        ram_addr     <= IDX_W'(sel_idx);
        ram_w_data   <= sel_wdata;
      end else begin
        ram_is_store <= 1'b0;
        ram_is_load  <= 1'b0;
        ram_w_enable <= '0;
        if (acc) ram_addr <= '0;
      end
    end
  end

  // Stage S2: the tag moves forward while the RAM performs the access on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_port  <= 1'b0;
      s2_load  <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_port  <= s1_port;
      s2_load  <= s1_load;
      s2_err   <= s1_err;
    end
  end

  // Route the response to the owning port; read data passes straight through from the RAM.
  always_comb begin
    p0_rvalid = s2_valid && !s2_port;
    p1_rvalid = s2_valid && s2_port;
    p0_err    = p0_rvalid && s2_err;
    p1_err    = p1_rvalid && s2_err;
    p0_rdata  = (p0_rvalid && s2_load && !s2_err) ? ram_r_data : 32'h0;
    p1_rdata  = (p1_rvalid && s2_load && !s2_err) ? ram_r_data : 32'h0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter, with a behavioural single-port RAM model.
module tb_ram_arbiter;

  localparam int DEPTH = 2561;
  localparam int IDX_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             p0_req, p0_we, p1_req, p1_we;
  logic [3:0]       p0_be, p1_be;
  logic [31:0]      p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic             p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0]      p0_rdata, p1_rdata;
  logic             ram_is_store, ram_is_load;
  logic [3:0]       ram_w_enable;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_w_data;
  logic [31:0]      ram_r_data;

  logic [31:0]      mem [DEPTH];
  int               n_vec = 0;
  int               n_miss = 0;

  ram_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_is_store(ram_is_store), .ram_is_load(ram_is_load), .ram_w_enable(ram_w_enable),
    .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // RAM model: word i preloads to 0xA5000000 | i, except word 8 which holds 0x11223344.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[8] <= 32'h1122_3344;
    end else begin
      if (ram_is_store)
        for (int b = 0; b < 4; b++)
          if (ram_w_enable[b]) mem[ram_addr][8*b +: 8] <= ram_w_data[8*b +: 8];
      if (ram_is_load) ram_r_data <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated request on one port, checked through grant, RAM command and response.
  task automatic xfer(input bit port, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input string name);
    @(negedge clk);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wdata;
    end
    #1;
    chk({name, ".gnt"}, port ? p1_gnt : p0_gnt, 32'd1);
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    chk({name, ".is_store"}, ram_is_store, (we && !exp_err) ? 32'd1 : 32'd0);
    chk({name, ".is_load"}, ram_is_load, (!we && !exp_err) ? 32'd1 : 32'd0);
    chk({name, ".w_enable"}, ram_w_enable, (we && !exp_err) ? {28'h0, be} : 32'd0);
    if (!exp_err) chk({name, ".ram_addr"}, ram_addr, {2'b00, addr[31:2]});
    @(negedge clk);
    chk({name, ".rvalid"}, port ? p1_rvalid : p0_rvalid, 32'd1);
    chk({name, ".other_rvalid"}, port ? p0_rvalid : p1_rvalid, 32'd0);
    chk({name, ".err"}, port ? p1_err : p0_err, exp_err ? 32'd1 : 32'd0);
    chk({name, ".rdata"}, port ? p1_rdata : p0_rdata, exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_be = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_be = 0; p1_addr = 0; p1_wdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst.is_store", ram_is_store, 0);
    chk("rst.is_load", ram_is_load, 0);
    chk("rst.w_enable", ram_w_enable, 0);
    chk("rst.ram_addr", ram_addr, 0);
    chk("rst.w_data", ram_w_data, 0);
    chk("rst.rvalid", {p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
    chk("rst.rdata", p0_rdata | p1_rdata, 0);

    xfer(0, 0, 4'h0, 32'h10, 32'h0, 32'hA500_0004, 0, "t1_ld");

    xfer(1, 1, 4'b0011, 32'h20, 32'hAABB_CCDD, 32'h0, 0, "t2_st");
    xfer(1, 0, 4'h0, 32'h20, 32'h0, 32'h1122_CCDD, 0, "t2_ld");

    // Tie for 6 cycles: p0 goes first because p1 was granted last.
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h40;
    p1_req = 1; p1_we = 0; p1_addr = 32'h80;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t3.gnt0[%0d]", k), p0_gnt, (k < 6 && k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3.gnt1[%0d]", k), p1_gnt, (k < 6 && k % 2 == 1) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk($sformatf("t3.rv0[%0d]", k), p0_rvalid, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("t3.rv1[%0d]", k), p1_rvalid, (k % 2 == 1) ? 32'd1 : 32'd0);
        if (k % 2 == 0) chk($sformatf("t3.rd0[%0d]", k), p0_rdata, 32'hA500_0010);
        else            chk($sformatf("t3.rd1[%0d]", k), p1_rdata, 32'hA500_0020);
      end else begin
        chk($sformatf("t3.rv_early[%0d]", k), {p0_rvalid, p1_rvalid}, 0);
      end
      @(posedge clk); #1;
      if (k == 5) begin p0_req = 0; p1_req = 0; end
      @(negedge clk);
    end

    xfer(0, 0, 4'h0, 32'h2804, 32'h0, 32'h0, 1, "t4_oob");
    xfer(0, 0, 4'h0, 32'h2800, 32'h0, 32'hA500_0A00, 0, "t4_top");

    // Store then load to word 12 on consecutive grants.
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_be = 4'hF; p0_addr = 32'h30; p0_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    p0_we = 0; p0_be = 4'h0;
    @(negedge clk);
    chk("t5.is_store", ram_is_store, 1);
    chk("t5.st_addr", ram_addr, 12);
    chk("t5.w_enable", ram_w_enable, 32'hF);
    chk("t5.w_data", ram_w_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    p0_req = 0;
    @(negedge clk);
    chk("t5.is_load", ram_is_load, 1);
    chk("t5.no_store", ram_is_store, 0);
    chk("t5.ack_rvalid", p0_rvalid, 1);
    chk("t5.ack_rdata", p0_rdata, 0);
    @(negedge clk);
    chk("t5.ld_rvalid", p0_rvalid, 1);
    chk("t5.ld_rdata", p0_rdata, 32'hDEAD_BEEF);

    // Reset with a p0 load in S1 and a p1 store in S2; p0 was granted last.
    @(negedge clk);
    p1_req = 1; p1_we = 1; p1_be = 4'hF; p1_addr = 32'h50; p1_wdata = 32'h5555_5555;
    #1 chk("t6.st_gnt", p1_gnt, 1);
    @(posedge clk); #1;
    p1_req = 0;
    p0_req = 1; p0_we = 0; p0_addr = 32'h50;
    @(posedge clk); #1;
    p0_req = 0;
    @(negedge clk);
    chk("t6.pre_load", ram_is_load, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6.async_load", ram_is_load, 0);
    chk("t6.async_store", ram_is_store, 0);
    chk("t6.async_rvalid", {p0_rvalid, p1_rvalid}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t6.no_rvalid[%0d]", k), {p0_rvalid, p1_rvalid}, 0);
    end
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    p1_req = 1; p1_we = 0; p1_addr = 32'h20;
    #1;
    chk("t6.tie_gnt0", p0_gnt, 1);
    chk("t6.tie_gnt1", p1_gnt, 0);
    @(posedge clk); #1;
    p0_req = 0; p1_req = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
